// File: rtl/div_pkg.sv
// div_pkg: shared widths, iteration bound and FSM state encoding for the divider
//   DIVD_W/DIVS_W/ACC_W : dividend, divisor and signed partial-remainder widths
//   ITER_LAST           : counter value of the final quotient-bit iteration
//   state_t             : controller states
package div_pkg;
    localparam int DIVD_W = 16;
    localparam int DIVS_W = 8;
    localparam int ACC_W  = 9;
    localparam logic [2:0] ITER_LAST = 3'd7;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_LO  = 3'd1;
    localparam logic [2:0] S_LOAD_DIV = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_ITER     = 3'd4;
    localparam logic [2:0] S_CORRECT  = 3'd5;
    localparam logic [2:0] S_OUT_Q    = 3'd6;
    localparam logic [2:0] S_OUT_R    = 3'd7;
    typedef enum logic [2:0] {
        IDLE     = S_IDLE,
        LOAD_LO  = S_LOAD_LO,
        LOAD_DIV = S_LOAD_DIV,
        CHECK    = S_CHECK,
        ITER     = S_ITER,
        CORRECT  = S_CORRECT,
        OUT_Q    = S_OUT_Q,
        OUT_R    = S_OUT_R
    } state_t;
endpackage

// File: rtl/div_addsub.sv
// div_addsub: combinational 9-bit adder/subtractor, result modulo 2^9
//   a, b : operands
//   sub  : 1 selects a - b, 0 selects a + b
//   y    : result
module div_addsub
    import div_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             sub,
    output logic [ACC_W-1:0] y
);
    assign y = sub ? a - b : a + b;
endmodule

// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: byte-serial 16/8 unsigned non-restoring divider
//   clk, rst_b : clock, asynchronous active-low reset
//   begin_op   : start request, honoured only in IDLE
//   inbus      : dividend high, dividend low, divisor on consecutive cycles
//   outbus     : quotient then remainder, 8'h00 otherwise
//   out_valid  : outbus carries a result byte
//   busy       : controller is not idle
//   err        : divide-by-zero or quotient overflow, qualified by out_valid
//   end_op     : pulse with the remainder byte
module nonrestoring_divider
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic       begin_op,
    input  logic [7:0] inbus,
    output logic [7:0] outbus,
    output logic       out_valid,
    output logic       busy,
    output logic       err,
    output logic       end_op
);
    state_t              state;
    logic [DIVD_W-1:0]   d;
    logic [DIVS_W-1:0]   v;
    logic [ACC_W-1:0]    a;
    logic [7:0]          qr;
    logic [2:0]          cnt;
    logic                err_q;
    logic [ACC_W-1:0]    as_a;
    logic [ACC_W-1:0]    as_y;
    logic                as_sub;

    // One adder serves both the iteration step (on the shifted remainder)
    // and the final sign correction (always an add).
    assign as_a   = state == ITER ? {a[ACC_W-2:0], qr[7]} : a;
    assign as_sub = state == ITER && !a[ACC_W-1];

    div_addsub u_addsub (
        .a   (as_a),
        .b   ({1'b0, v}),
        .sub (as_sub),
        .y   (as_y)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            d     <= '0;
            v     <= '0;
            a     <= '0;
            qr    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (begin_op) begin
                    d[15:8] <= inbus;
                    err_q   <= 1'b0;
                    state   <= LOAD_LO;
                end
                LOAD_LO: begin
                    d[7:0] <= inbus;
                    state  <= LOAD_DIV;
                end
                LOAD_DIV: begin
                    v     <= inbus;
                    state <= CHECK;
                end
                // A high byte not below the divisor means the quotient
                // cannot fit in 8 bits.
                CHECK: if (v == '0 || d[15:8] >= v) begin
                    err_q <= 1'b1;
                    state <= OUT_Q;
                end else begin
                    a     <= {1'b0, d[15:8]};
                    qr    <= d[7:0];
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    a     <= as_y;
                    qr    <= {qr[6:0], ~as_y[ACC_W-1]};
                    cnt   <= cnt + 3'd1;
                    state <= cnt == ITER_LAST ? CORRECT : ITER;
                end
                // A negative final remainder is restored by one add.
                CORRECT: begin
                    if (a[ACC_W-1])
                        a <= as_y;
                    state <= OUT_Q;
                end
                OUT_Q: state <= OUT_R;
                OUT_R: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = state != IDLE;
    assign out_valid = state == OUT_Q || state == OUT_R;
    assign end_op    = state == OUT_R;
    assign err       = err_q && out_valid;
    assign outbus    = !out_valid || err_q ? 8'h00 : state == OUT_Q ? qr : a[7:0];
endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb_nonrestoring_divider: directed and randomized checks against an arithmetic reference
module tb_nonrestoring_divider;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       begin_op = 1'b0;
    logic [7:0] inbus = 8'h00;
    logic [7:0] outbus;
    logic       out_valid, busy, err, end_op;
    int         errors = 0;
    int         checks = 0;

    nonrestoring_divider dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .begin_op  (begin_op),
        .inbus     (inbus),
        .outbus    (outbus),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err),
        .end_op    (end_op)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; overflow or zero divisor gives err and zero bytes.
    function automatic logic [16:0] ref_div(input logic [15:0] dd, input logic [7:0] vv);
        int q, r;
        if (vv == 0) return {1'b1, 16'h0000};
        q = int'(dd) / int'(vv);
        r = int'(dd) % int'(vv);
        if (q > 255) return {1'b1, 16'h0000};
        return {1'b0, q[7:0], r[7:0]};
    endfunction

    // Drives one operation; edge counts are relative to the edge that samples begin_op (T0).
    task automatic do_op(input logic [7:0] hi, lo, vv, output logic [7:0] q, r,
                         output logic eq, er, output int tq, tr, output logic bad);
        q = 0; r = 0; eq = 0; er = 0; tq = -1; tr = -1; bad = 0;
        @(posedge clk); #1 begin_op = 1'b1; inbus = hi;
        @(posedge clk); #1 begin_op = 1'b0; inbus = lo;
        @(posedge clk); #1 inbus = vv;
        @(posedge clk); #1 inbus = 8'h00;
        for (int t = 3; t < 40 && tr < 0; t++) begin
            @(posedge clk); #1;
            if (!out_valid && outbus !== 8'h00) bad = 1'b1;
            if (out_valid && !end_op && tq < 0) begin q = outbus; eq = err; tq = t; end
            if (end_op) begin r = outbus; er = err; tr = t; end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, out_valid, end_op, err, outbus} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %b %b %h expected all zero", busy, out_valid, end_op, err, outbus);
        end
        @(negedge clk); rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 checks++;
        if ({busy, out_valid, end_op, err, outbus} !== 12'h000) begin
            errors++;
            $display("FAIL post_reset_quiet got %b %b %b %b %h expected all zero", busy, out_valid, end_op, err, outbus);
        end
    endtask

    task automatic test_directed;
        logic [7:0] vec [6][3] = '{
            '{8'h03, 8'hE8, 8'h07}, '{8'hFE, 8'h01, 8'hFF}, '{8'h12, 8'h34, 8'h00},
            '{8'h01, 8'h00, 8'h01}, '{8'h00, 8'hFF, 8'h01}, '{8'h00, 8'h64, 8'h0A}};
        logic [7:0] exq [6] = '{8'h8E, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h0A};
        logic [7:0] exr [6] = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       exe [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] q, r;
        logic       eq, er, bad;
        int         tq, tr;
        for (int i = 0; i < 6; i++) begin
            do_op(vec[i][0], vec[i][1], vec[i][2], q, r, eq, er, tq, tr, bad);
            checks++;
            if ({q, r, eq, er} !== {exq[i], exr[i], exe[i], exe[i]}) begin
                errors++;
                $display("FAIL directed_%0d got q=%h r=%h err=%b/%b expected q=%h r=%h err=%b", i, q, r, eq, er, exq[i], exr[i], exe[i]);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL directed_%0d_idle_bus got nonzero outbus while invalid expected 00", i);
            end
            checks++;
            if (exe[i] ? (tr != tq + 1 || tr >= 13 || tq < 3) : (tq != 12 || tr != 13)) begin
                errors++;
                $display("FAIL directed_%0d_latency got tq=%0d tr=%0d expected %s", i, tq, tr, exe[i] ? "shortened path" : "tq=12 tr=13");
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] q, r;
        logic       eq, er, bad;
        int         tr, tq;
        bit         got_end;
        @(posedge clk); #1 begin_op = 1'b1; inbus = 8'h03;
        @(posedge clk); #1 begin_op = 1'b0; inbus = 8'hE8;
        @(posedge clk); #1 inbus = 8'h07;
        @(posedge clk); #1 inbus = 8'h55;
        repeat (3) @(posedge clk);
        #1 begin_op = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_op got %b expected 1", busy);
        end
        @(posedge clk); #1 begin_op = 1'b0;
        q = 0; r = 0; tr = -1;
        for (int t = 7; t < 40 && tr < 0; t++) begin
            @(posedge clk); #1;
            if (out_valid && !end_op) q = outbus;
            if (end_op) begin r = outbus; tr = t; end
        end
        checks++;
        if ({q, r} !== 16'h8E06 || tr != 13) begin
            errors++;
            $display("FAIL begin_ignored got q=%h r=%h t=%0d expected q=8e r=06 t=13", q, r, tr);
        end
        begin_op = 1'b1;
        @(posedge clk); #1 begin_op = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL out_r_begin_ignored got busy=%b expected 0", busy);
        end
        @(posedge clk); #1 begin_op = 1'b1; inbus = 8'h03;
        @(posedge clk); #1 begin_op = 1'b0; inbus = 8'hE8;
        @(posedge clk); #1 inbus = 8'h07;
        repeat (6) @(posedge clk);
        #1 rst_b = 1'b0;
        #1 checks++;
        if ({busy, out_valid, end_op, err, outbus} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset got %b %b %b %b %h expected all zero", busy, out_valid, end_op, err, outbus);
        end
        @(negedge clk); rst_b = 1'b1;
        got_end = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || out_valid || end_op) got_end = 1;
        end
        checks++;
        if (got_end) begin
            errors++;
            $display("FAIL reset_abort got activity after reset expected none");
        end
        do_op(8'h00, 8'h64, 8'h0A, q, r, eq, er, tq, tr, bad);
        checks++;
        if ({q, r, eq, er} !== {8'h0A, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL after_reset_op got q=%h r=%h err=%b%b expected q=0a r=00 err=00", q, r, eq, er);
        end
    endtask

    task automatic test_random;
        logic [7:0]  hi, lo, vv, q, r;
        logic        eq, er, bad;
        logic [16:0] ex;
        int          tq, tr;
        for (int i = 0; i < 3000; i++) begin
            vv = 8'($urandom);
            if ($urandom_range(0, 15) == 0) vv = 8'h00;
            hi = (vv != 0 && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, int'(vv) - 1)) : 8'($urandom);
            lo = 8'($urandom);
            ex = ref_div({hi, lo}, vv);
            do_op(hi, lo, vv, q, r, eq, er, tq, tr, bad);
            checks++;
            if ({eq, q, r} !== ex || er !== ex[16] || bad || tr < 0) begin
                errors++;
                $display("FAIL random_%0d %h%h/%h got err=%b%b q=%h r=%h bad=%b t=%0d expected err=%b q=%h r=%h",
                         i, hi, lo, vv, eq, er, q, r, bad, tr, ex[16], ex[15:8], ex[7:0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_busy_ignore;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
